// File: rtl/axi_lite_arb_pkg.sv
// Shared types and helpers for the AXI4-Lite port arbiter.
// Holds the FSM state encoding, the operation codes and a width helper.
package axi_lite_arb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StDone  = 2'd3
    } arb_state_e;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    // Ceiling log2, never below 1, so that index vectors stay at least one bit wide.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(value)) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/axi_lite_port_arbiter_if.sv
// Request/response bus between the arbiter and the shared AXI4-Lite master block.
// The arbiter uses the master modport; the master block uses the slave modport.
interface axi_lite_port_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) ();

    logic                  m_rd_req;
    logic                  m_wr_req;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic [DATA_WIDTH-1:0] m_wdata;
    logic                  m_done;
    logic [DATA_WIDTH-1:0] m_rdata;
    logic                  m_err;

    modport master (
        output m_rd_req, m_wr_req, m_addr, m_wdata,
        input  m_done, m_rdata, m_err
    );

    modport slave (
        input  m_rd_req, m_wr_req, m_addr, m_wdata,
        output m_done, m_rdata, m_err
    );

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin select: first pending index at or after the pointer, wrapping.
// Bits below the pointer are masked out of a doubled pend vector, so the upper copy handles wrap.
module rr_priority_pick
    import axi_lite_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W    = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pend,
    input  logic [ID_W-1:0]    pointer,
    output logic [ID_W-1:0]    winner,
    output logic               any_valid
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [2*NUM_REQ-1:0] masked;

    always_comb begin
        dbl    = {pend, pend};
        masked = '0;
        winner = '0;
        for (int j = 0; j < 2 * NUM_REQ; j++) begin
            masked[j] = dbl[j] && (j >= int'(pointer));
        end
        // Descending scan leaves the lowest set index as the final assignment.
        for (int j = 2 * NUM_REQ - 1; j >= 0; j--) begin
            if (masked[j]) begin
                winner = ID_W'(j % NUM_REQ);
            end
        end
        any_valid = |pend;
    end

endmodule

// File: rtl/axi_lite_port_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master among NUM_REQ requesters,
// one transaction at a time, with a watchdog that force-completes hung transactions.
module axi_lite_port_arbiter
    import axi_lite_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ    = 4,
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned ADDR_WIDTH = 32,
    parameter  int unsigned TIMEOUT    = 255,
    localparam int unsigned ID_W       = clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_rd,
    input  logic [NUM_REQ-1:0]             req_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             req_ack,
    output logic                           req_err,
    output logic [DATA_WIDTH-1:0]          req_rdata,
    axi_lite_port_arbiter_if.master        m_bus,
    output logic [ID_W-1:0]                grant_id,
    output logic                           busy
);

    localparam logic [15:0]     TimeoutVal = 16'(TIMEOUT);
    localparam logic [ID_W-1:0] LastId     = ID_W'(NUM_REQ - 1);

    arb_state_e            state_q, state_d;
    logic [ID_W-1:0]       grant_q, grant_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic                  op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [15:0]           wd_q, wd_d;

    logic [NUM_REQ-1:0]    pend;
    logic [ID_W-1:0]       winner;
    logic                  any_valid;

    assign pend = req_rd | req_wr;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .pend      (pend),
        .pointer   (ptr_q),
        .winner    (winner),
        .any_valid (any_valid)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        wd_d    = '0;
        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    grant_d = winner;
                    addr_d  = req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d = req_wdata[winner*DATA_WIDTH +: DATA_WIDTH];
                    op_d    = req_wr[winner] ? OP_WR : OP_RD;
                    if (req_rd[winner] && req_wr[winner]) begin
                        // Read and write together is illegal: fail it without touching the bus.
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = StDone;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue, StWait: begin
                if (state_q == StWait) begin
                    wd_d = wd_q + 16'd1;
                end
                if (m_bus.m_done) begin
                    rdata_d = (op_q == OP_RD) ? m_bus.m_rdata : '0;
                    err_d   = m_bus.m_err;
                    state_d = StDone;
                end else if (state_q == StWait && wd_d == TimeoutVal) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    state_d = StWait;
                end
            end
            StDone: begin
                ptr_d   = (grant_q == LastId) ? '0 : grant_q + 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= '0;
            op_q    <= OP_RD;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        req_ack = '0;
        if (state_q == StDone) begin
            req_ack[grant_q] = 1'b1;
        end
        req_err        = err_q && (state_q == StDone);
        req_rdata      = rdata_q;
        grant_id       = grant_q;
        busy           = (state_q != StIdle);
        m_bus.m_rd_req = (state_q == StIssue) && (op_q == OP_RD);
        m_bus.m_wr_req = (state_q == StIssue) && (op_q == OP_WR);
        m_bus.m_addr   = addr_q;
        m_bus.m_wdata  = wdata_q;
    end

endmodule
